// File: rtl/fpnew_aux_lanes.sv
// fpnew_aux_lanes: shared tag/aux/lane-mask handshake pipeline with per-lane stage enables and an in-flight credit limit
module fpnew_aux_lanes #(
  parameter int unsigned NumPipeRegs = 2,
  parameter int unsigned NumLanes = 4,
  parameter int unsigned MaxInFlight = NumPipeRegs,
  parameter type TagType = logic,
  parameter type AuxType = logic,
  parameter int unsigned CntWidth = (NumPipeRegs == 0) ? 1 : $clog2(NumPipeRegs + 1),
  localparam int unsigned EnWidth = (NumPipeRegs == 0) ? 1 : NumLanes * NumPipeRegs
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  TagType              tag_i,
  input  AuxType              aux_i,
  input  logic [NumLanes-1:0] lane_mask_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output TagType              tag_o,
  output AuxType              aux_o,
  output logic [NumLanes-1:0] lane_mask_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [EnWidth-1:0]  reg_enable_o,
  output logic [CntWidth-1:0] occupancy_o,
  output logic                busy_o
);
  if (NumPipeRegs == 0) begin : gen_bypass
    logic unused;
    assign unused = ^{clk_i, rst_i, flush_i};
    assign tag_o = tag_i;
    assign aux_o = aux_i;
    assign lane_mask_o = lane_mask_i;
    assign out_valid_o = in_valid_i;
    assign in_ready_o = out_ready_i;
    assign reg_enable_o = '0;
    assign occupancy_o = '0;
    assign busy_o = in_valid_i;
  end else begin : gen_pipe
    localparam int N = NumPipeRegs;
    localparam int L = NumLanes;
    logic [N:1] valid_q;
    logic [N:0] ready;
    logic [N-1:0] en;
    logic [CntWidth-1:0] occ_q;
    logic out_hs;
    TagType tag_q [1:N];
    AuxType aux_q [1:N];
    logic [L-1:0] mask_q [1:N];
    TagType tag_s [0:N];
    AuxType aux_s [0:N];
    logic [L-1:0] mask_s [0:N];
    always_comb begin
      tag_s[0] = tag_i;
      aux_s[0] = aux_i;
      mask_s[0] = lane_mask_i;
      for (int i = 1; i <= N; i++) begin
        tag_s[i] = tag_q[i];
        aux_s[i] = aux_q[i];
        mask_s[i] = mask_q[i];
      end
    end
    always_comb begin
      ready = '0;
      en = '0;
      reg_enable_o = '0;
      ready[N] = out_ready_i;
      for (int i = N - 1; i >= 0; i--) ready[i] = ready[i+1] | ~valid_q[i+1];
      out_hs = valid_q[N] & out_ready_i;
      in_ready_o = ready[0] & ((occ_q < CntWidth'(MaxInFlight)) | out_hs);
      en[0] = in_valid_i & in_ready_o;
      for (int i = 1; i < N; i++) en[i] = ready[i] & valid_q[i];
      for (int i = 0; i < N; i++)
        for (int l = 0; l < L; l++)
          reg_enable_o[l*N+i] = en[i] & mask_s[i][l];
    end
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= '0;
        occ_q <= '0;
        for (int i = 1; i <= N; i++) begin
          tag_q[i] <= '0;
          aux_q[i] <= '0;
          mask_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < N; i++) begin
          if (ready[i]) valid_q[i+1] <= en[i];
          if (en[i]) begin
            tag_q[i+1] <= tag_s[i];
            aux_q[i+1] <= aux_s[i];
            mask_q[i+1] <= mask_s[i];
          end
        end
        occ_q <= flush_i ? '0 : occ_q + CntWidth'(en[0]) - CntWidth'(out_hs);
        if (flush_i) valid_q <= '0;
      end
    end
    assign tag_o = tag_s[N];
    assign aux_o = aux_s[N];
    assign lane_mask_o = mask_s[N];
    assign out_valid_o = valid_q[N];
    assign occupancy_o = occ_q;
    assign busy_o = in_valid_i | (|valid_q);
  end
endmodule

// File: tb/tb_fpnew_aux_lanes.sv
// tb_fpnew_aux_lanes: item-level reference model check of fpnew_aux_lanes at N=2, N=4 (credit 2) and N=0
module tb_fpnew_aux_lanes;
  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [7:0] tag_in;
  logic [3:0] aux_in, lane_mask;
  logic in_ready_a, out_valid_a, busy_a;
  logic [7:0] tag_o_a;
  logic [3:0] aux_o_a, mask_o_a;
  logic [7:0] ren_a;
  logic [1:0] occ_a;
  logic in_ready_b, out_valid_b, busy_b;
  logic [7:0] tag_o_b;
  logic [3:0] aux_o_b, mask_o_b;
  logic [15:0] ren_b;
  logic [2:0] occ_b;
  logic in_ready_c, out_valid_c, busy_c;
  logic [7:0] tag_o_c;
  logic [3:0] aux_o_c, mask_o_c;
  logic [0:0] ren_c;
  logic [0:0] occ_c;
  typedef struct {
    logic [7:0] tag;
    logic [3:0] aux;
    logic [3:0] mask;
    int pos;
  } item_t;
  item_t pipe [2][8];
  int cnt [2] = '{0, 0};
  bit mv [2][8];
  bit acc [2], hs_m [2];
  logic exp_ir [2], exp_ov [2];
  logic [7:0] exp_tag [2];
  logic [3:0] exp_aux [2], exp_mask [2];
  logic [15:0] exp_en [2];
  logic post_rst = 1'b0;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  fpnew_aux_lanes #(.NumPipeRegs(2), .NumLanes(4), .MaxInFlight(2), .TagType(logic [7:0]), .AuxType(logic [3:0])) dut_a (
    .clk_i(clk), .rst_i(rst), .tag_i(tag_in), .aux_i(aux_in), .lane_mask_i(lane_mask),
    .in_valid_i(in_valid), .in_ready_o(in_ready_a), .flush_i(flush), .tag_o(tag_o_a), .aux_o(aux_o_a),
    .lane_mask_o(mask_o_a), .out_valid_o(out_valid_a), .out_ready_i(out_ready),
    .reg_enable_o(ren_a), .occupancy_o(occ_a), .busy_o(busy_a));
  fpnew_aux_lanes #(.NumPipeRegs(4), .NumLanes(4), .MaxInFlight(2), .TagType(logic [7:0]), .AuxType(logic [3:0])) dut_b (
    .clk_i(clk), .rst_i(rst), .tag_i(tag_in), .aux_i(aux_in), .lane_mask_i(lane_mask),
    .in_valid_i(in_valid), .in_ready_o(in_ready_b), .flush_i(flush), .tag_o(tag_o_b), .aux_o(aux_o_b),
    .lane_mask_o(mask_o_b), .out_valid_o(out_valid_b), .out_ready_i(out_ready),
    .reg_enable_o(ren_b), .occupancy_o(occ_b), .busy_o(busy_b));
  fpnew_aux_lanes #(.NumPipeRegs(0), .NumLanes(4), .TagType(logic [7:0]), .AuxType(logic [3:0])) dut_c (
    .clk_i(clk), .rst_i(rst), .tag_i(tag_in), .aux_i(aux_in), .lane_mask_i(lane_mask),
    .in_valid_i(in_valid), .in_ready_o(in_ready_c), .flush_i(flush), .tag_o(tag_o_c), .aux_o(aux_o_c),
    .lane_mask_o(mask_o_c), .out_valid_o(out_valid_c), .out_ready_i(out_ready),
    .reg_enable_o(ren_c), .occupancy_o(occ_c), .busy_o(busy_c));
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic predict(input int k, input int n, input int mx);
    int c;
    logic rdy0, hs;
    c = cnt[k];
    exp_en[k] = '0;
    for (int j = 0; j < c; j++) begin
      if (j == 0) mv[k][j] = (pipe[k][j].pos < n) || out_ready;
      else mv[k][j] = (pipe[k][j].pos + 1 < pipe[k][j-1].pos) || mv[k][j-1];
      if (mv[k][j] && pipe[k][j].pos < n)
        for (int l = 0; l < 4; l++)
          if (pipe[k][j].mask[l]) exp_en[k][l*n + pipe[k][j].pos] = 1'b1;
    end
    hs = c > 0 && pipe[k][0].pos == n && out_ready;
    rdy0 = c == 0 || pipe[k][c-1].pos > 1 || mv[k][c-1];
    exp_ir[k] = rdy0 && (c < mx || hs);
    acc[k] = in_valid && exp_ir[k];
    hs_m[k] = hs;
    if (acc[k])
      for (int l = 0; l < 4; l++)
        if (lane_mask[l]) exp_en[k][l*n] = 1'b1;
    exp_ov[k] = c > 0 && pipe[k][0].pos == n;
    if (c > 0) begin
      exp_tag[k] = pipe[k][0].tag;
      exp_aux[k] = pipe[k][0].aux;
      exp_mask[k] = pipe[k][0].mask;
    end
  endtask
  task automatic advance(input int k);
    if (rst || flush) begin
      cnt[k] = 0;
      return;
    end
    for (int j = 0; j < cnt[k]; j++)
      if (mv[k][j]) pipe[k][j].pos++;
    if (hs_m[k]) begin
      for (int j = 1; j < cnt[k]; j++) pipe[k][j-1] = pipe[k][j];
      cnt[k]--;
    end
    if (acc[k]) begin
      pipe[k][cnt[k]] = '{tag: tag_in, aux: aux_in, mask: lane_mask, pos: 1};
      cnt[k]++;
    end
  endtask
  task automatic check_inst(input int k, input string p, input logic ir, input logic ov, input logic [7:0] tg,
                            input logic [3:0] ax, input logic [3:0] mk, input logic [15:0] ren,
                            input logic [2:0] occ, input logic bz);
    chk({p, ".in_ready"}, 32'(ir), 32'(exp_ir[k]));
    chk({p, ".out_valid"}, 32'(ov), 32'(exp_ov[k]));
    chk({p, ".reg_enable"}, 32'(ren), 32'(exp_en[k]));
    chk({p, ".occupancy"}, 32'(occ), 32'(cnt[k]));
    chk({p, ".busy"}, 32'(bz), 32'(in_valid | (cnt[k] != 0)));
    if (exp_ov[k]) begin
      chk({p, ".tag"}, 32'(tg), 32'(exp_tag[k]));
      chk({p, ".aux"}, 32'(ax), 32'(exp_aux[k]));
      chk({p, ".mask"}, 32'(mk), 32'(exp_mask[k]));
    end
    if (post_rst) begin
      chk({p, ".tag_after_rst"}, 32'(tg), 0);
      chk({p, ".aux_after_rst"}, 32'(ax), 0);
      chk({p, ".mask_after_rst"}, 32'(mk), 0);
    end
  endtask
  task automatic cycle(input logic iv, input logic [7:0] tg, input logic [3:0] m,
                       input logic ordy, input logic fl, input logic r);
    @(negedge clk);
    in_valid = iv;
    tag_in = tg;
    lane_mask = m;
    aux_in = 4'($urandom);
    out_ready = ordy;
    flush = fl;
    rst = r;
    #1;
    predict(0, 2, 2);
    predict(1, 4, 2);
    check_inst(0, "a", in_ready_a, out_valid_a, tag_o_a, aux_o_a, mask_o_a, 16'(ren_a), 3'(occ_a), busy_a);
    check_inst(1, "b", in_ready_b, out_valid_b, tag_o_b, aux_o_b, mask_o_b, ren_b, occ_b, busy_b);
    chk("c.out_valid", 32'(out_valid_c), 32'(in_valid));
    chk("c.in_ready", 32'(in_ready_c), 32'(out_ready));
    chk("c.data", {12'(tag_o_c), aux_o_c, mask_o_c, ren_c, occ_c, busy_c}, {12'(tag_in), aux_in, lane_mask, 2'b00, in_valid});
    @(posedge clk);
    advance(0);
    advance(1);
    post_rst = r;
  endtask
  initial begin
    int ordy_pct;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tag_in = '0;
    aux_in = '0;
    lane_mask = '0;
    repeat (2) @(posedge clk);
    post_rst = 1'b1;
    for (int t = 1; t <= 5; t++) cycle(1'b1, 8'(t), 4'b0101, 1'b1, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 8'h00, 4'b0101, 1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 3; t++) cycle(1'b1, 8'(16 + t), 4'b1111, 1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 5; t++) cycle(1'b1, 8'(20 + t), 4'b0011, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 8; t++) cycle(1'b1, 8'(25 + t), 4'b0110, 1'b1, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 6; t++) cycle(1'b1, 8'(40 + t), 4'b1000, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 6; t++) cycle(1'b1, 8'(48 + t), 4'b0000, 1'b1, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h60, 4'b0001, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 4'b0001, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h61, 4'b0010, 1'b0, 1'b0, 1'b0);
    repeat (4) cycle(1'b0, 8'h00, 4'b0000, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h70, 4'b1111, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h71, 4'b1111, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h72, 4'b1111, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 8'h73, 4'b1010, 1'b1, 1'b0, 1'b0);
    repeat (5) cycle(1'b0, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);
    for (int t = 0; t < 5; t++) cycle(1'b1, 8'(128 + t), 4'b1111, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h90, 4'b1111, 1'b0, 1'b1, 1'b1);
    for (int t = 0; t < 6; t++) cycle(1'b1, 8'(160 + t), 4'b0101, 1'b1, 1'b0, 1'b0);
    ordy_pct = 50;
    for (int t = 0; t < 3000; t++) begin
      if (t % 64 == 0) ordy_pct = $urandom_range(10, 100);
      cycle($urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom), $urandom_range(1, 100) <= ordy_pct,
            $urandom_range(0, 40) == 0, $urandom_range(0, 200) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
